// File: rtl/motor_packet_uart.sv
// Packetized serial command generator for a two-motor driver board.
// Turns direction/speed into 8N1 UART packets, resent on change and on a periodic refresh.
module motor_packet_uart #(
    parameter int         CLKS_PER_BIT   = 434,
    parameter logic [7:0] ADDRESS        = 8'd128,
    parameter int         REFRESH_CYCLES = 5_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] direction,
    input  logic [2:0] speed,
    output logic       uart_out,
    output logic       busy,
    output logic       pkt_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CW-1:0] BIT_LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] STOP_LAST    = CW'(CLKS_PER_BIT - 2);
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, AUTOBAUD, LOAD, SEND_BYTE, NEXT_BYTE, DONE} state_t;

    state_t        state;
    logic [CW-1:0] clk_cnt;
    logic [3:0]    bit_cnt;
    logic [2:0]    byte_idx;
    logic [8:0]    frame;
    logic [2:0]    dir_s;
    logic [2:0]    spd_s;
    logic [5:0]    prev_cmd;
    logic          pending;
    logic          autobaud_needed;
    logic          sending_ab;
    logic [RW-1:0] refresh_cnt;

    logic change;
    logic request;

    function automatic logic [7:0] pkt_byte(input logic [2:0] idx,
                                            input logic [2:0] dir,
                                            input logic [2:0] spd);
        logic       fwd;
        logic       rev;
        logic [7:0] data;
        logic [7:0] cmd1;
        logic [7:0] cmd2;
        fwd  = (dir == 3'b001);
        rev  = (dir == 3'b011);
        data = (fwd || rev) ? 8'(spd) * 8'd18 : 8'd0;
        cmd1 = rev ? 8'd1 : 8'd0;
        cmd2 = rev ? 8'd5 : 8'd4;
        case (idx)
            3'd0, 3'd4: pkt_byte = ADDRESS;
            3'd1:       pkt_byte = cmd1;
            3'd2, 3'd6: pkt_byte = data;
            3'd3:       pkt_byte = (ADDRESS + cmd1 + data) & 8'h7F;
            3'd5:       pkt_byte = cmd2;
            default:    pkt_byte = (ADDRESS + cmd2 + data) & 8'h7F;
        endcase
    endfunction

    // A change seen this cycle counts as a request so IDLE reacts without waiting for pending.
    assign change  = ({direction, speed} != prev_cmd);
    assign request = autobaud_needed || pending || change || (refresh_cnt == REFRESH_LAST);

    always_ff @(posedge clk) begin
        prev_cmd <= {direction, speed};
    end

    // The final cycle of every stop bit is spent in NEXT_BYTE or LOAD so bytes stay gapless.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            uart_out        <= 1'b1;
            busy            <= 1'b0;
            pkt_done        <= 1'b0;
            refresh_cnt     <= '0;
            pending         <= 1'b0;
            autobaud_needed <= 1'b1;
            sending_ab      <= 1'b0;
            clk_cnt         <= '0;
            bit_cnt         <= 4'd0;
            byte_idx        <= 3'd0;
            frame           <= '1;
            dir_s           <= 3'd0;
            spd_s           <= 3'd0;
        end else begin
            pkt_done <= 1'b0;
            if (change) pending <= 1'b1;
            case (state)
                IDLE: begin
                    uart_out <= 1'b1;
                    busy     <= 1'b0;
                    if (refresh_cnt != REFRESH_LAST) refresh_cnt <= refresh_cnt + RW'(1);
                    if (request) state <= autobaud_needed ? AUTOBAUD : LOAD;
                end
                AUTOBAUD: begin
                    autobaud_needed <= 1'b0;
                    sending_ab      <= 1'b1;
                    frame           <= {1'b1, 8'hAA};
                    uart_out        <= 1'b0;
                    busy            <= 1'b1;
                    clk_cnt         <= '0;
                    bit_cnt         <= 4'd0;
                    state           <= SEND_BYTE;
                end
                LOAD: begin
                    dir_s      <= direction;
                    spd_s      <= speed;
                    pending    <= 1'b0;
                    sending_ab <= 1'b0;
                    byte_idx   <= 3'd0;
                    frame      <= {1'b1, ADDRESS};
                    uart_out   <= 1'b0;
                    busy       <= 1'b1;
                    clk_cnt    <= '0;
                    bit_cnt    <= 4'd0;
                    state      <= SEND_BYTE;
                end
                SEND_BYTE: begin
                    if (bit_cnt == 4'd9 && clk_cnt == STOP_LAST) begin
                        state <= sending_ab ? LOAD : NEXT_BYTE;
                    end else if (clk_cnt == BIT_LAST) begin
                        clk_cnt  <= '0;
                        bit_cnt  <= bit_cnt + 4'd1;
                        uart_out <= frame[0];
                        frame    <= {1'b1, frame[8:1]};
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                NEXT_BYTE: begin
                    if (byte_idx == 3'd7) begin
                        pkt_done <= 1'b1;
                        uart_out <= 1'b1;
                        busy     <= 1'b0;
                        state    <= DONE;
                    end else begin
                        byte_idx <= byte_idx + 3'd1;
                        frame    <= {1'b1, pkt_byte(byte_idx + 3'd1, dir_s, spd_s)};
                        uart_out <= 1'b0;
                        clk_cnt  <= '0;
                        bit_cnt  <= 4'd0;
                        state    <= SEND_BYTE;
                    end
                end
                DONE: begin
                    refresh_cnt <= '0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/motor_packet_uart.md
Name: motor_packet_uart

Overview:
- Serial command generator between direction_fsm/speed logic and the motor driver board on GPIO[5].
- Replaces the separate forward/backwards/stop sequencers with one block.
- Converts a 3-bit direction code and 3-bit speed into Sabertooth-style packetized serial frames for both motors, sent as 8N1 UART.
- Resends on any command change and on a periodic refresh, so the driver's serial timeout never trips.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200).
- ADDRESS, 8'd128, driver packet address byte.
- REFRESH_CYCLES, 5_000_000, idle cycles before an unchanged command is resent (100 ms).

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- rst  in  1  synchronous, active-high reset.
- direction  in  3  3'b001 forward, 3'b011 reverse, any other value stop.
- speed  in  3  speed level 0..7; ignored when stopped.
- uart_out  out  1  serial TX line, idle high.
- busy  out  1  high while any frame bit is on the line.
- pkt_done  out  1  one-cycle pulse after the last stop bit of a full two-motor packet.

Behaviour:
- Reset values: uart_out=1, busy=0, pkt_done=0, refresh counter=0, pending=0, autobaud_needed=1.
- UART framing:
  - 8N1, LSB first: start bit 0, data[0..7], stop bit 1.
  - Each bit is held exactly CLKS_PER_BIT cycles.
  - Bytes go back-to-back with no idle gap.
- Command mapping, snapshotted into shadow registers (dir_s, spd_s) when a transmission starts:
  - data = spd_s*18, range 0..126, 8-bit.
  - Forward: motor1 cmd=0, motor2 cmd=4.
  - Reverse: motor1 cmd=1, motor2 cmd=5.
  - Stop: cmd=0/4 with data=0.
- Packet content: 8 bytes in order ADDRESS, cmd1, data, chk1, ADDRESS, cmd2, data, chk2.
- Checksum: chk = (ADDRESS+cmd+data) mod 256, masked with 8'h7F.
- FSM states: IDLE, AUTOBAUD, LOAD, SEND_BYTE, NEXT_BYTE, DONE.
  - IDLE: stays until a request is present.
  - A request is autobaud_needed, pending, or refresh counter == REFRESH_CYCLES-1.
  - AUTOBAUD: sends the single byte 8'hAA, clears autobaud_needed, then goes to LOAD (no pkt_done).
  - LOAD: snapshots inputs, clears pending, sets byte index to 0.
  - SEND_BYTE: shifts out 10 bits.
  - NEXT_BYTE: increments the index; returns to SEND_BYTE if the index is below 8, otherwise goes to DONE.
  - DONE: pulses pkt_done for 1 cycle, clears the refresh counter, returns to IDLE.
- Latency: the start bit appears the cycle after the FSM leaves IDLE (LOAD/AUTOBAUD take 1 cycle).
- busy is high from the first start-bit cycle through the last stop-bit cycle, and low in IDLE/DONE.
- Change detection: registered previous {direction,speed}, compared every cycle.
  - Any mismatch sets pending.
  - A speed change while the effective direction is stop is still a change; spec keeps it simple.
  - A change mid-packet does not alter the frame in flight.
  - pending makes the next packet start immediately after DONE.
  - Multiple changes during one packet collapse into one resend using the latest values.
- Refresh counter:
  - Counts only in IDLE, saturates at REFRESH_CYCLES-1.
  - Change and refresh coincident → one packet.
- Reset mid-operation: line returns high on the next cycle; a partial byte is abandoned; the autobaud byte is sent again after reset.
- Direction codes 3'b000, 010, 1xx all encode as stop.

Test Plan (CLKS_PER_BIT=4, REFRESH_CYCLES=200):
- Release rst with direction=000:
  - Required: a 0xAA frame, then bytes 80 00 00 00 80 04 00 04.
  - pkt_done pulses once after 90 bit times (360 cycles).
  - uart_out is high before and after.
- direction=001, speed=7 applied in IDLE → packet 80 00 7E 7E 80 04 7E 02; the start bit begins 2 cycles after the input change.
- direction=011, speed=7 → packet 80 01 7E 7F 80 05 7E 03.
- Change direction to 001/speed=3 at byte 2 of a reverse packet:
  - Required: the current packet completes unchanged.
  - Then, with no idle gap beyond DONE, packet 80 00 36 36 80 04 36 3A.
- Hold inputs constant after a packet → an identical packet restarts when 200 IDLE cycles elapse; repeats periodically.
- Assert rst for 1 cycle during byte 5 → uart_out=1 and busy=0 next cycle, then the sequence restarts with 0xAA.
